// File: rtl/execute_stage.sv
// Execute stage: latches decoded operands, computes the integer ALU / predicate result,
// and runs div/mod on a 1-bit-per-cycle restoring divider behind valid/ready handshakes.
module execute_stage #(
  parameter int                WIDTH     = 32,
  parameter logic [WIDTH-1:0]  DIV0_QUOT = 32'hFFFF_FFFF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [6:0]       ex,
  input  logic [1:0]       mem,
  input  logic [3:0]       wb,
  input  logic [WIDTH-1:0] rx,
  input  logic [WIDTH-1:0] ry,
  input  logic             px,
  input  logic             py,
  input  logic [WIDTH-1:0] imm_s,
  input  logic [3:0]       z_in,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic [WIDTH-1:0] store_data,
  output logic             pz,
  output logic [3:0]       z_out,
  output logic [1:0]       mem_out,
  output logic [3:0]       wb_out
);
  typedef enum logic {IDLE, DIV_BUSY} state_t;

  state_t           r_state;
  logic [5:0]       r_cnt;
  logic [WIDTH-1:0] r_rem, r_quot, r_dvsr, r_a;
  logic             r_qneg, r_div0, r_mod;
  logic             r_valid, r_pz;
  logic [WIDTH-1:0] r_result, r_sd;
  logic [3:0]       r_z, r_wb;
  logic [1:0]       r_mem;

  logic [3:0]       w_op;
  logic [WIDTH-1:0] w_op2, w_res, w_amag, w_bmag;
  logic             w_pz, w_is_div, w_accept, w_unused;
  logic [WIDTH-1:0] w_sh, w_q_nxt, w_r_nxt, w_q_fin, w_r_fin;
  logic [WIDTH:0]   w_sub;

  assign w_unused = ex[6];
  assign w_op     = ex[4:1];
  assign w_op2    = ex[5] ? imm_s : ry;
  assign w_is_div = ex[0] & ((w_op == 4'b0100) | (w_op == 4'b0101));
  assign in_ready = (r_state == IDLE) & (~r_valid | out_ready) & ~flush & ~rst;
  assign w_accept = in_valid & in_ready;

  always_comb begin
    w_res = '0;
    w_pz  = 1'b0;
    if (ex[0]) begin
      case (w_op)
        4'b0001: w_res = rx + w_op2;
        4'b0010: w_res = rx - w_op2;
        4'b0011: w_res = rx * w_op2;
        4'b0110: w_res = rx << w_op2[4:0];
        4'b0111: w_res = rx >> w_op2[4:0];
        4'b1000: w_res = rx & w_op2;
        4'b1001: w_res = rx | w_op2;
        4'b1010: w_res = rx ^ w_op2;
        4'b1011: w_res = -rx;
        4'b1100: w_res = ~rx;
        4'b1101: w_res = w_op2;
        default: w_res = '0;
      endcase
    end else begin
      case (w_op)
        4'b0001: w_pz = px & py;
        4'b0010: w_pz = px | py;
        4'b0011: w_pz = px ^ py;
        4'b0100: w_pz = ~px;
        4'b0101: w_pz = (rx != '0);
        4'b0110: w_pz = rx[WIDTH-1];
        4'b0111: w_pz = (rx == '0);
        default: w_pz = 1'b0;
      endcase
    end
  end

  // Restoring step on magnitudes; r_quot shifts the dividend out as quotient bits shift in.
  assign w_amag  = rx[WIDTH-1] ? -rx : rx;
  assign w_bmag  = w_op2[WIDTH-1] ? -w_op2 : w_op2;
  assign w_sh    = {r_rem[WIDTH-2:0], r_quot[WIDTH-1]};
  assign w_sub   = {1'b0, w_sh} - {1'b0, r_dvsr};
  assign w_q_nxt = {r_quot[WIDTH-2:0], ~w_sub[WIDTH]};
  assign w_r_nxt = w_sub[WIDTH] ? w_sh : w_sub[WIDTH-1:0];
  assign w_q_fin = r_div0 ? DIV0_QUOT : (r_qneg ? -w_q_nxt : w_q_nxt);
  assign w_r_fin = r_div0 ? r_a : (r_a[WIDTH-1] ? -w_r_nxt : w_r_nxt);

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= IDLE;   r_cnt  <= '0;
      r_rem   <= '0;     r_quot <= '0;  r_dvsr <= '0;  r_a <= '0;
      r_qneg  <= 1'b0;   r_div0 <= 1'b0; r_mod <= 1'b0;
      r_valid <= 1'b0;   r_result <= '0; r_sd <= '0;   r_pz <= 1'b0;
      r_z     <= '0;     r_mem <= '0;    r_wb <= '0;
    end else if (flush) begin
      r_state <= IDLE;
      r_cnt   <= '0;
      r_valid <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          if (w_accept) begin
            r_sd  <= ry;
            r_z   <= z_in;
            r_mem <= mem;
            r_wb  <= wb;
            if (w_is_div) begin
              r_state <= DIV_BUSY;
              r_cnt   <= 6'd32;
              r_valid <= 1'b0;
              r_pz    <= 1'b0;
              r_rem   <= '0;
              r_quot  <= w_amag;
              r_dvsr  <= w_bmag;
              r_a     <= rx;
              r_qneg  <= rx[WIDTH-1] ^ w_op2[WIDTH-1];
              r_div0  <= (w_op2 == '0);
              r_mod   <= w_op[0];
            end else begin
              r_valid  <= 1'b1;
              r_result <= w_res;
              r_pz     <= w_pz;
            end
          end else if (out_ready) begin
            r_valid <= 1'b0;
          end
        end
        DIV_BUSY: begin
          r_rem  <= w_r_nxt;
          r_quot <= w_q_nxt;
          r_cnt  <= r_cnt - 6'd1;
          if (r_cnt == 6'd1) begin
            r_state  <= IDLE;
            r_valid  <= 1'b1;
            r_result <= r_mod ? w_r_fin : w_q_fin;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign out_valid  = r_valid;
  assign result     = r_result;
  assign store_data = r_sd;
  assign pz         = r_pz;
  assign z_out      = r_z;
  assign mem_out    = r_mem;
  assign wb_out     = r_wb;
endmodule

// File: tb/tb_execute_stage.sv
// Directed bench for execute_stage: ALU, predicate, divider corners, backpressure, flush, reset.
module tb_execute_stage;
  logic        clk = 0, rst, flush, in_valid, in_ready, out_valid, out_ready;
  logic [6:0]  ex;
  logic [1:0]  mem, mem_out;
  logic [3:0]  wb, wb_out, z_in, z_out;
  logic [31:0] rx, ry, imm_s, result, store_data;
  logic        px, py, pz;
  int total = 0, bad = 0;

  execute_stage dut (
    .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid), .in_ready(in_ready),
    .ex(ex), .mem(mem), .wb(wb), .rx(rx), .ry(ry), .px(px), .py(py), .imm_s(imm_s),
    .z_in(z_in), .out_valid(out_valid), .out_ready(out_ready), .result(result),
    .store_data(store_data), .pz(pz), .z_out(z_out), .mem_out(mem_out), .wb_out(wb_out)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic setop(input logic [6:0] e, input logic [31:0] a, input logic [31:0] b,
                       input logic [31:0] imm, input logic p1, input logic p2);
    ex = e; rx = a; ry = b; imm_s = imm; px = p1; py = p2;
  endtask

  task automatic issue(input logic [6:0] e, input logic [31:0] a, input logic [31:0] b,
                       input logic [31:0] imm, input logic p1, input logic p2);
    setop(e, a, b, imm, p1, p2);
    in_valid = 1; tick(); in_valid = 0;
  endtask

  task automatic div_run(input string tag, input logic [6:0] e, input logic [31:0] a,
                         input logic [31:0] b, input logic [31:0] exp);
    int n;
    issue(e, a, b, 0, 0, 0);
    chk({tag, "_busy_rdy"}, {31'b0, in_ready}, 0);
    n = 0;
    while (!out_valid && n < 40) begin tick(); n++; end
    chk({tag, "_lat"}, n, 32);
    chk(tag, result, exp);
    tick();
  endtask

  localparam logic [6:0] ADDI = 7'b0_1_0001_1, SUB = 7'b0_0_0010_1, MULI = 7'b0_1_0011_1,
    SHR = 7'b0_0_0111_1, NEG = 7'b0_0_1011_1, DIV = 7'b0_0_0100_1, MOD = 7'b0_0_0101_1,
    PZERO = 7'b0_0_0111_0, PNEG = 7'b0_0_0110_0, PXOR = 7'b0_0_0011_0, PAND = 7'b0_0_0001_0;

  initial begin
    int n;
    rst = 1; flush = 0; in_valid = 0; out_ready = 1; mem = 0; wb = 0; z_in = 0;
    setop(0, 0, 0, 0, 0, 0);
    tick();
    chk("rst_rdy", {31'b0, in_ready}, 0);
    tick();
    chk("rst_vld", {31'b0, out_valid}, 0);
    chk("rst_res", result, 0);
    rst = 0; #1;
    chk("idle_rdy", {31'b0, in_ready}, 1);

    // add imm with control passthrough
    wb = 4'b0101; mem = 2'b10; z_in = 4'd3;
    issue(ADDI, 5, 0, 32'hFFFF_FFFD, 0, 0);
    chk("add_vld", {31'b0, out_valid}, 1);
    chk("add_res", result, 2);
    chk("add_wb", {28'b0, wb_out}, 5);
    chk("add_mem", {30'b0, mem_out}, 2);
    chk("add_z", {28'b0, z_out}, 3);
    chk("add_pz", {31'b0, pz}, 0);
    tick();
    chk("drain_vld", {31'b0, out_valid}, 0);
    wb = 0; mem = 0; z_in = 0;

    issue(SUB, 10, 3, 0, 0, 0);
    chk("sub_res", result, 7);
    chk("sub_sd", store_data, 3);
    issue(MULI, 32'hFFFF_FFFC, 0, 6, 0, 0);
    chk("mul_res", result, 32'hFFFF_FFE8);
    issue(SHR, 32'h8000_0000, 31, 0, 0, 0);
    chk("shr_res", result, 1);
    issue(NEG, 5, 0, 0, 0, 0);
    chk("neg_res", result, 32'hFFFF_FFFB);
    issue(7'b0, 32'h1234, 32'h55, 0, 1, 1);
    chk("bubble_vld", {31'b0, out_valid}, 1);
    chk("bubble_res", result, 0);
    chk("bubble_pz", {31'b0, pz}, 0);
    tick();

    div_run("div_neg", DIV, 32'hFFFF_FFF9, 2, 32'hFFFF_FFFD);
    div_run("mod_neg", MOD, 32'hFFFF_FFF9, 2, 32'hFFFF_FFFF);
    div_run("div_zero", DIV, 9, 0, 32'hFFFF_FFFF);
    div_run("mod_zero", MOD, 9, 0, 9);
    div_run("div_ovf", DIV, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000);
    div_run("mod_ovf", MOD, 32'h8000_0000, 32'hFFFF_FFFF, 0);
    div_run("div_pos", DIV, 100, 7, 14);

    // predicates
    issue(PZERO, 0, 0, 0, 0, 0);
    chk("iszero_pz", {31'b0, pz}, 1);
    issue(PNEG, 32'h8000_0000, 0, 0, 0, 0);
    chk("isneg_pz", {31'b0, pz}, 1);
    chk("isneg_res", result, 0);
    issue(PXOR, 7, 0, 0, 1, 1);
    chk("xorp_pz", {31'b0, pz}, 0);
    issue(PAND, 0, 0, 0, 1, 1);
    chk("andp_pz", {31'b0, pz}, 1);
    tick();

    // backpressure: stall 4 cycles with a queued op
    out_ready = 0;
    issue(ADDI, 1, 0, 1, 0, 0);
    setop(SUB, 9, 4, 0, 0, 0);
    in_valid = 1;
    for (int i = 0; i < 4; i++) begin
      chk("bp_vld", {31'b0, out_valid}, 1);
      chk("bp_res", result, 2);
      chk("bp_rdy", {31'b0, in_ready}, 0);
      tick();
    end
    out_ready = 1; #1;
    chk("bp_rel_rdy", {31'b0, in_ready}, 1);
    tick(); in_valid = 0;
    chk("bp_next_vld", {31'b0, out_valid}, 1);
    chk("bp_next_res", result, 5);
    tick();
    chk("bp_clear", {31'b0, out_valid}, 0);

    // flush mid-divide
    issue(DIV, 100, 7, 0, 0, 0);
    repeat (9) tick();
    flush = 1; #1;
    chk("flush_rdy", {31'b0, in_ready}, 0);
    tick(); flush = 0; #1;
    chk("flush_vld", {31'b0, out_valid}, 0);
    chk("flush_idle", {31'b0, in_ready}, 1);
    n = 0;
    for (int i = 0; i < 40; i++) begin if (out_valid) n++; tick(); end
    chk("flush_no_out", n, 0);
    issue(ADDI, 40, 0, 2, 0, 0);
    chk("post_flush_res", result, 42);
    tick();

    // reset mid-divide (with flush) clears every output
    wb = 4'hF; mem = 2'b11; z_in = 4'hA;
    issue(DIV, 100, 7, 0, 0, 0);
    chk("pre_rst_wb", {28'b0, wb_out}, 4'hF);
    repeat (9) tick();
    rst = 1; flush = 1; tick(); rst = 0; flush = 0; #1;
    chk("rst2_vld", {31'b0, out_valid}, 0);
    chk("rst2_res", result, 0);
    chk("rst2_sd", store_data, 0);
    chk("rst2_ctl", {22'b0, pz, z_out, mem_out, wb_out}, 0);
    chk("rst2_rdy", {31'b0, in_ready}, 1);
    n = 0;
    for (int i = 0; i < 40; i++) begin if (out_valid) n++; tick(); end
    chk("rst2_no_out", n, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
